// File: rtl/legv8_pkg.sv
// LEGv8 encoder shared definitions: operation enum, opcode constants and field widths.
// Opcode constants are left-justified into bit 31 by the field packer.
package legv8_pkg;

   typedef enum logic [3:0] {
      OP_B    = 4'd0,
      OP_BL   = 4'd1,
      OP_CBZ  = 4'd2,
      OP_CBNZ = 4'd3,
      OP_LDUR = 4'd4,
      OP_STUR = 4'd5,
      OP_ADD  = 4'd6,
      OP_SUB  = 4'd7,
      OP_AND  = 4'd8,
      OP_ORR  = 4'd9,
      OP_ADDI = 4'd10,
      OP_SUBI = 4'd11,
      OP_ANDI = 4'd12,
      OP_ORRI = 4'd13,
      OP_MOVK = 4'd14
   } op_e;

   localparam logic [5:0]  OPC_B    = 6'b000101;
   localparam logic [5:0]  OPC_BL   = 6'b100101;
   localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
   localparam logic [7:0]  OPC_CBNZ = 8'b10110101;
   localparam logic [10:0] OPC_LDUR = 11'b11111000010;
   localparam logic [10:0] OPC_STUR = 11'b11111000000;
   localparam logic [10:0] OPC_ADD  = 11'b10001011000;
   localparam logic [10:0] OPC_SUB  = 11'b11001011000;
   localparam logic [10:0] OPC_AND  = 11'b10001010000;
   localparam logic [10:0] OPC_ORR  = 11'b10101010000;
   localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
   localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
   localparam logic [9:0]  OPC_ANDI = 10'b1001001000;
   localparam logic [9:0]  OPC_ORRI = 10'b1011001000;
   localparam logic [8:0]  OPC_MOVK = 9'b111100101;

   localparam int unsigned IMM_W      = 26;
   localparam int unsigned IMM_CB_W   = 19;
   localparam int unsigned IMM_D_W    = 9;
   localparam int unsigned IMM_I_W    = 12;
   localparam int unsigned IMM_MOVK_W = 16;

   // True when the immediate has no set bits above the field width w.
   function automatic logic imm_fits(input logic [IMM_W-1:0] imm, input int unsigned w);
      return (imm >> w) == '0;
   endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational LEGv8 field packer: operation plus operands -> 32-bit word and reject flag.
// Register-form ops carry no immediate, so in_imm is ignored for them.
module instr_field_pack
   import legv8_pkg::*;
(
   input  logic [3:0]       op_i,
   input  logic [4:0]       rd_i,
   input  logic [4:0]       rn_i,
   input  logic [4:0]       rm_i,
   input  logic [IMM_W-1:0] imm_i,
   input  logic [1:0]       hw_i,
   output logic [31:0]      instr_o,
   output logic             reject_o
);

   always_comb begin
      instr_o  = '0;
      reject_o = 1'b0;
      case (op_i)
         OP_B:    instr_o = {OPC_B,  imm_i[25:0]};
         OP_BL:   instr_o = {OPC_BL, imm_i[25:0]};
         OP_CBZ, OP_CBNZ: begin
            instr_o  = {(op_i == OP_CBZ) ? OPC_CBZ : OPC_CBNZ, imm_i[18:0], rd_i};
            reject_o = !imm_fits(imm_i, IMM_CB_W);
         end
         OP_LDUR, OP_STUR: begin
            instr_o  = {(op_i == OP_LDUR) ? OPC_LDUR : OPC_STUR, imm_i[8:0], 2'b00, rn_i, rd_i};
            reject_o = !imm_fits(imm_i, IMM_D_W);
         end
         OP_ADD:  instr_o = {OPC_ADD, rm_i, 6'd0, rn_i, rd_i};
         OP_SUB:  instr_o = {OPC_SUB, rm_i, 6'd0, rn_i, rd_i};
         OP_AND:  instr_o = {OPC_AND, rm_i, 6'd0, rn_i, rd_i};
         OP_ORR:  instr_o = {OPC_ORR, rm_i, 6'd0, rn_i, rd_i};
         OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI: begin
            case (op_i)
               OP_ADDI: instr_o = {OPC_ADDI, imm_i[11:0], rn_i, rd_i};
               OP_SUBI: instr_o = {OPC_SUBI, imm_i[11:0], rn_i, rd_i};
               OP_ANDI: instr_o = {OPC_ANDI, imm_i[11:0], rn_i, rd_i};
               default: instr_o = {OPC_ORRI, imm_i[11:0], rn_i, rd_i};
            endcase
            reject_o = !imm_fits(imm_i, IMM_I_W);
         end
         OP_MOVK: begin
            instr_o  = {OPC_MOVK, hw_i, imm_i[15:0], rd_i};
            reject_o = !imm_fits(imm_i, IMM_MOVK_W);
         end
         default: reject_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// LEGv8 instruction encoder: ready/valid request in, one registered encoded word plus word address out.
// Rejected requests are consumed silently and only counted.
module instr_encoder
   import legv8_pkg::*;
#(
   parameter int unsigned START_ADDR = 0,
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned ERRCNT_W   = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                clear,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [3:0]          in_op,
   input  logic [4:0]          in_rd,
   input  logic [4:0]          in_rn,
   input  logic [4:0]          in_rm,
   input  logic [25:0]         in_imm,
   input  logic [1:0]          in_hw,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [31:0]         out_instr,
   output logic [ADDR_W-1:0]   out_addr,
   output logic                err_sticky,
   output logic [ERRCNT_W-1:0] err_count
);

   localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);

   logic                out_valid_q,  out_valid_d;
   logic [31:0]         out_instr_q,  out_instr_d;
   logic [ADDR_W-1:0]   out_addr_q,   out_addr_d;
   logic                err_sticky_q, err_sticky_d;
   logic [ERRCNT_W-1:0] err_count_q,  err_count_d;

   logic [31:0] pack_instr;
   logic        pack_reject;
   logic        accept;
   logic        handshake;

   instr_field_pack u_pack (
      .op_i     (in_op),
      .rd_i     (in_rd),
      .rn_i     (in_rn),
      .rm_i     (in_rm),
      .imm_i    (in_imm),
      .hw_i     (in_hw),
      .instr_o  (pack_instr),
      .reject_o (pack_reject)
   );

   assign in_ready  = !out_valid_q || out_ready;
   assign accept    = in_valid && in_ready;
   assign handshake = out_valid_q && out_ready;

   // out_addr_q tags whatever word sits in the output stage, so advancing it on the
   // handshake gives a same-edge accepted word the next address automatically.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_instr_d  = out_instr_q;
      out_addr_d   = out_addr_q;
      err_sticky_d = err_sticky_q;
      err_count_d  = err_count_q;
      if (handshake) begin
         out_valid_d = 1'b0;
         out_addr_d  = out_addr_q + ADDR_W'(1);
      end
      if (accept) begin
         if (pack_reject) begin
            err_sticky_d = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + ERRCNT_W'(1);
         end else begin
            out_valid_d = 1'b1;
            out_instr_d = pack_instr;
         end
      end
      if (clear) begin
         out_addr_d   = START;
         err_sticky_d = 1'b0;
         err_count_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_valid_q  <= 1'b0;
         out_instr_q  <= '0;
         out_addr_q   <= START;
         err_sticky_q <= 1'b0;
         err_count_q  <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_instr_q  <= out_instr_d;
         out_addr_q   <= out_addr_d;
         err_sticky_q <= err_sticky_d;
         err_count_q  <= err_count_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_instr  = out_instr_q;
   assign out_addr   = out_addr_q;
   assign err_sticky = err_sticky_q;
   assign err_count  = err_count_q;

endmodule
